// File: rtl/aes_core_arbiter.sv
// rtl/aes_core_arbiter.sv - round-robin arbiter sharing one AES core between two requesters
// Tracks whose key schedule is loaded so consecutive blocks from one owner skip key expansion.
module aes_core_arbiter #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int TW          = 11
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         r0_req_i,
  input  logic [255:0] r0_key_i,
  input  logic [1:0]   r0_key_mode_i,
  input  logic         r0_ende_i,
  input  logic         r0_key_new_i,
  input  logic [127:0] r0_data_i,
  output logic         r0_ack_o,
  input  logic         r1_req_i,
  input  logic [255:0] r1_key_i,
  input  logic [1:0]   r1_key_mode_i,
  input  logic         r1_ende_i,
  input  logic         r1_key_new_i,
  input  logic [127:0] r1_data_i,
  output logic         r1_ack_o,
  output logic [127:0] rsp_data_o,
  output logic         rsp_err_o,
  output logic         core_start_o,
  output logic         core_enable_o,
  output logic         core_ende_o,
  output logic [255:0] core_key_o,
  output logic [1:0]   core_key_mode_o,
  output logic [127:0] core_data_o,
  output logic         core_dvalid_o,
  input  logic         core_ready_i,
  input  logic         core_key_rdy_i,
  input  logic [127:0] core_dout_i,
  input  logic         core_dout_v_i
);

  typedef enum logic [2:0] {S_IDLE, S_KEYLD, S_KEYWT, S_SEND, S_RESWT, S_ACK} state_e;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e         state_q, state_d;
  logic           grant_q, grant_d;
  logic           last_grant_q, last_grant_d;
  logic           cache_vld_q, cache_vld_d;
  logic           cache_owner_q, cache_owner_d;
  logic [1:0]     cache_mode_q, cache_mode_d;
  logic [255:0]   key_q, key_d;
  logic [1:0]     mode_q, mode_d;
  logic           ende_q, ende_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;
  logic           start_q, start_d;
  logic           dvalid_q, dvalid_d;
  logic           ack0_q, ack0_d;
  logic           ack1_q, ack1_d;
  logic           prev_q, prev_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           enable_q;
  logic           sel, sel_key_new, abort, tmo_hit;
  logic [1:0]     sel_mode;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    cache_vld_d   = cache_vld_q;
    cache_owner_d = cache_owner_q;
    cache_mode_d  = cache_mode_q;
    key_d         = key_q;
    mode_d        = mode_q;
    ende_d        = ende_q;
    data_d        = data_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    prev_d        = prev_q;
    start_d       = 1'b0;
    dvalid_d      = 1'b0;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    abort         = 1'b0;
    tmo_hit       = (tmo_q == TMO_LAST);
    // On a tie the requester that was not served last wins.
    sel           = r1_req_i & (~r0_req_i | ~last_grant_q);
    sel_mode      = sel ? r1_key_mode_i : r0_key_mode_i;
    sel_key_new   = sel ? r1_key_new_i : r0_key_new_i;

    unique case (state_q)
      S_IDLE: begin
        if (r0_req_i || r1_req_i) begin
          grant_d = sel;
          key_d   = sel ? r1_key_i : r0_key_i;
          mode_d  = sel_mode;
          ende_d  = sel ? r1_ende_i : r0_ende_i;
          data_d  = sel ? r1_data_i : r0_data_i;
          if (!cache_vld_q || cache_owner_q != sel || cache_mode_q != sel_mode || sel_key_new) begin
            state_d = S_KEYLD;
            start_d = 1'b1;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_KEYLD: begin
        cache_vld_d = 1'b0;
        state_d     = S_KEYWT;
      end
      S_KEYWT: begin
        if (core_key_rdy_i) begin
          cache_vld_d   = 1'b1;
          cache_owner_d = grant_q;
          cache_mode_d  = mode_q;
          state_d       = S_SEND;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
      S_SEND: begin
        prev_d = core_dout_v_i;
        if (core_ready_i) begin
          dvalid_d = 1'b1;
          state_d  = S_RESWT;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
      S_RESWT: begin
        prev_d = core_dout_v_i;
        if (!prev_q && core_dout_v_i) begin
          rsp_data_d = core_dout_i;
          rsp_err_d  = 1'b0;
          state_d    = S_ACK;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
      S_ACK: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      rsp_data_d  = '0;
      rsp_err_d   = 1'b1;
      cache_vld_d = 1'b0;
      state_d     = S_ACK;
    end

    if (state_d == S_ACK && state_q != S_ACK) begin
      ack0_d = ~grant_q;
      ack1_d = grant_q;
    end

    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (state_q == S_KEYWT || state_q == S_SEND || state_q == S_RESWT) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = '0;
    end

    // Uses the owner being written this cycle so a key change racing key_rdy still invalidates.
    if ((r0_key_new_i && !cache_owner_d) || (r1_key_new_i && cache_owner_d)) begin
      cache_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      cache_vld_q   <= 1'b0;
      cache_owner_q <= 1'b0;
      cache_mode_q  <= 2'b00;
      key_q         <= '0;
      mode_q        <= 2'b00;
      ende_q        <= 1'b0;
      data_q        <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      start_q       <= 1'b0;
      dvalid_q      <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      prev_q        <= 1'b0;
      tmo_q         <= '0;
      enable_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      cache_vld_q   <= cache_vld_d;
      cache_owner_q <= cache_owner_d;
      cache_mode_q  <= cache_mode_d;
      key_q         <= key_d;
      mode_q        <= mode_d;
      ende_q        <= ende_d;
      data_q        <= data_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      start_q       <= start_d;
      dvalid_q      <= dvalid_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      prev_q        <= prev_d;
      tmo_q         <= tmo_d;
      enable_q      <= 1'b1;
    end
  end

  assign r0_ack_o        = ack0_q;
  assign r1_ack_o        = ack1_q;
  assign rsp_data_o      = rsp_data_q;
  assign rsp_err_o       = rsp_err_q;
  assign core_start_o    = start_q;
  assign core_enable_o   = enable_q;
  assign core_ende_o     = ende_q;
  assign core_key_o      = key_q;
  assign core_key_mode_o = mode_q;
  assign core_data_o     = data_q;
  assign core_dvalid_o   = dvalid_q;

endmodule
